// File: rtl/mac_mul_slice_pipe_if.sv
// Operand/result handshake bundle for one cross-multiply slice.
// The slave view is the slice; the master view is the driver/consumer side.
interface mac_mul_slice_pipe_if #(
    parameter int unsigned MAC_MIN_WIDTH  = 8,
    parameter int unsigned MAC_CONF_WIDTH = 2,
    parameter int unsigned MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH
);
    logic                        en;
    logic                        in_valid;
    logic                        in_ready;
    logic [4*MAC_MIN_WIDTH-1:0]  A;
    logic [MAC_MIN_WIDTH-1:0]    B;
    logic [MAC_CONF_WIDTH-1:0]   cfg;
    logic                        out_valid;
    logic                        out_ready;
    logic [MAC_INT_WIDTH-1:0]    C;
    logic                        cfg_err;

    modport master (
        output en, in_valid, A, B, cfg, out_ready,
        input  in_ready, out_valid, C, cfg_err
    );

    modport slave (
        input  en, in_valid, A, B, cfg, out_ready,
        output in_ready, out_valid, C, cfg_err
    );
endinterface

// File: rtl/mac_mul_slice_pipe.sv
// Two-stage pipelined cross-multiply slice: lane LANE_IDX multiplies its B byte by the
// A bytes of its single/dual/quad lane group and returns the composed row product.
module mac_mul_slice_pipe #(
    parameter int unsigned MAC_MIN_WIDTH  = 8,
    parameter int unsigned MAC_CONF_WIDTH = 2,
    parameter int unsigned LANE_IDX       = 3,
    parameter int unsigned MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    mac_mul_slice_pipe_if.slave     bus
);
    localparam int unsigned W  = MAC_MIN_WIDTH;
    localparam int unsigned PW = 2 * MAC_MIN_WIDTH;

    localparam logic [MAC_CONF_WIDTH-1:0] CFG_SINGLE = MAC_CONF_WIDTH'(0);
    localparam logic [MAC_CONF_WIDTH-1:0] CFG_DUAL   = MAC_CONF_WIDTH'(1);
    localparam logic [MAC_CONF_WIDTH-1:0] CFG_RSVD   = MAC_CONF_WIDTH'(3);
    localparam logic [1:0]                LANE       = 2'(LANE_IDX);

    logic                      s1_valid;
    logic [MAC_CONF_WIDTH-1:0] s1_cfg;
    logic [PW-1:0]             s1_prod [4];
    logic                      out_valid_q;
    logic [MAC_INT_WIDTH-1:0]  c_q;
    logic                      cfg_err_q;

    logic                      s2_adv_c;
    logic                      s1_adv_c;
    logic                      in_ready_c;
    logic                      accept_c;
    logic [PW-1:0]             prod_c [4];
    logic [1:0]                grp_mask_c;
    logic [1:0]                g0_c;
    logic [MAC_INT_WIDTH-1:0]  sum_c;

    // Flow control: a stalled S2 lets S1 hold one more beat before backpressure
    assign s2_adv_c   = !out_valid_q || bus.out_ready;
    assign s1_adv_c   = s1_valid && s2_adv_c;
    assign in_ready_c = bus.en && (!s1_valid || s2_adv_c);
    assign accept_c   = bus.in_valid && in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.C         = c_q;
    assign bus.cfg_err   = cfg_err_q;

    // All four lane products are formed; S2 picks the group
    for (genvar i = 0; i < 4; i++) begin : g_prod
        assign prod_c[i] = PW'(bus.A[i*W +: W]) * PW'(bus.B);
    end

    // Group mask clears the low lane-index bits that vary inside a group
    always_comb begin
        grp_mask_c = 2'b00;
        case (s1_cfg)
            CFG_SINGLE: grp_mask_c = 2'b11;
            CFG_DUAL:   grp_mask_c = 2'b10;
            default:    grp_mask_c = 2'b00;
        endcase
        g0_c = LANE & grp_mask_c;
    end

    // Compose the group's partial products at W-bit offsets relative to lane g0
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 4; i++) begin
            if ((2'(i) & grp_mask_c) == g0_c) begin
                sum_c = sum_c + (MAC_INT_WIDTH'(s1_prod[i]) << (W * 32'(2'(i) - g0_c)));
            end
        end
        if (s1_cfg == CFG_RSVD) begin
            sum_c = '0;
        end
    end

    // Stage 1: products and cfg captured per accepted beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_cfg   <= '0;
            for (int i = 0; i < 4; i++) begin
                s1_prod[i] <= '0;
            end
        end else if (bus.en) begin
            if (accept_c) begin
                s1_valid <= 1'b1;
                s1_cfg   <= bus.cfg;
                s1_prod  <= prod_c;
            end else if (s1_adv_c) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: result register; cfg_err only on the cycle a reserved beat first appears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            cfg_err_q   <= 1'b0;
        end else if (bus.en) begin
            if (s2_adv_c) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    c_q <= sum_c;
                end
            end
            cfg_err_q <= s2_adv_c && s1_valid && (s1_cfg == CFG_RSVD);
        end
    end
endmodule

// File: tb/tb_mac_mul_slice_pipe.sv
// Bench for mac_mul_slice_pipe: lane 3 and lane 1 slices driven in lockstep against a
// queue-based reference of in-flight beats.
module tb_mac_mul_slice_pipe;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 5 * W;

    typedef struct {
        logic [39:0] c3;
        logic [39:0] c1;
        bit          err;
        bit          shown;
        int          vis;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [7:0]  b;
    logic [1:0]  cfg;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t q[$];

    mac_mul_slice_pipe_if #(.MAC_MIN_WIDTH(W), .MAC_CONF_WIDTH(2), .MAC_INT_WIDTH(IW)) bus3 ();
    mac_mul_slice_pipe_if #(.MAC_MIN_WIDTH(W), .MAC_CONF_WIDTH(2), .MAC_INT_WIDTH(IW)) bus1 ();

    assign bus3.en = en;        assign bus1.en = en;
    assign bus3.in_valid = in_valid;   assign bus1.in_valid = in_valid;
    assign bus3.out_ready = out_ready; assign bus1.out_ready = out_ready;
    assign bus3.A = a;          assign bus1.A = a;
    assign bus3.B = b;          assign bus1.B = b;
    assign bus3.cfg = cfg;      assign bus1.cfg = cfg;

    mac_mul_slice_pipe #(.MAC_MIN_WIDTH(W), .MAC_CONF_WIDTH(2), .LANE_IDX(3), .MAC_INT_WIDTH(IW))
        u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    mac_mul_slice_pipe #(.MAC_MIN_WIDTH(W), .MAC_CONF_WIDTH(2), .LANE_IDX(1), .MAC_INT_WIDTH(IW))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Group operand as an integer, times B
    function automatic logic [39:0] ref_c(input int lane, input logic [31:0] av,
                                          input logic [7:0] bv, input logic [1:0] cf);
        int          g;
        int          g0;
        logic [63:0] grp;
        if (cf == 2'b11) return 40'd0;
        g   = 1 << cf;
        g0  = (lane / g) * g;
        grp = 64'(av) >> (8 * g0);
        if (g < 4) grp = grp & ((64'd1 << (8 * g)) - 64'd1);
        return 40'(grp * 64'(bv));
    endfunction

    // One clock: check outputs against the model, then advance the model across the edge
    task automatic cycle(output bit acc);
        bit    ov;
        bit    ir;
        bit    ce;
        bit    cons;
        beat_t nb;
        beat_t t;
        #1;
        ov = (q.size() > 0) && q[0].shown;
        ce = ov && q[0].err && (q[0].vis == 0);
        ir = en && ((q.size() < 2) || out_ready);
        chk("out_valid3", 64'(bus3.out_valid), 64'(ov));
        chk("out_valid1", 64'(bus1.out_valid), 64'(ov));
        chk("in_ready3",  64'(bus3.in_ready),  64'(ir));
        chk("in_ready1",  64'(bus1.in_ready),  64'(ir));
        chk("cfg_err3",   64'(bus3.cfg_err),   64'(ce));
        chk("cfg_err1",   64'(bus1.cfg_err),   64'(ce));
        if (ov) begin
            chk("c3", 64'(bus3.C), 64'(q[0].c3));
            chk("c1", 64'(bus1.C), 64'(q[0].c1));
        end
        acc      = in_valid && ir;
        cons     = en && ov && out_ready;
        nb.c3    = ref_c(3, a, b, cfg);
        nb.c1    = ref_c(1, a, b, cfg);
        nb.err   = (cfg == 2'b11);
        nb.shown = 1'b0;
        nb.vis   = 0;
        @(posedge clk);
        if (en) begin
            if (cons) void'(q.pop_front());
            if (q.size() > 0) begin
                t = q[0];
                if (t.shown) t.vis++;
                else t.shown = 1'b1;
                q[0] = t;
            end
            if (acc) q.push_back(nb);
        end
        @(negedge clk);
    endtask

    task automatic one_beat(input string tag, input logic [31:0] av, input logic [7:0] bv,
                            input logic [1:0] cf, input logic [39:0] exp3,
                            input logic [39:0] exp1, input bit exp_err);
        bit acc;
        a = av; b = bv; cfg = cf; in_valid = 1'b1; out_ready = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        chk({tag, "_lat"},  64'(bus3.out_valid), 64'd1);
        chk({tag, "_c3"},   64'(bus3.C), 64'(exp3));
        chk({tag, "_c1"},   64'(bus1.C), 64'(exp1));
        chk({tag, "_err"},  64'(bus3.cfg_err), 64'(exp_err));
        cycle(acc);
    endtask

    initial begin
        bit          acc;
        int          sent;
        logic [31:0] bp_a [4];
        logic [7:0]  bp_b [4];

        en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cfg = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus3.out_valid), 64'd0);
        chk("rst_c",         64'(bus3.C),         64'd0);
        chk("rst_cfg_err",   64'(bus3.cfg_err),   64'd0);
        @(negedge clk);
        rst = 1'b1;

        one_beat("single", 32'hFF00_0000, 8'hFF, 2'b00, 40'h00_0000_FE01, 40'h0, 1'b0);
        one_beat("dual",   32'h1234_1234, 8'h56, 2'b01, 40'h00_0006_1D78, 40'h00_0006_1D78, 1'b0);
        one_beat("quad",   32'hFFFF_FFFF, 8'hFF, 2'b10, 40'hFE_FFFF_FF01, 40'hFE_FFFF_FF01, 1'b0);
        one_beat("rsvd",   32'hFFFF_FFFF, 8'hFF, 2'b11, 40'h0, 40'h0, 1'b1);

        // Back-to-back beats of mixed cfg, reserved beat followed by clean ones
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = $urandom; b = 8'($urandom);
            cfg = (i == 2) ? 2'b11 : 2'(i % 3);
            cycle(acc);
        end
        in_valid = 1'b0;
        repeat (3) cycle(acc);

        // Backpressure: 4 beats with the consumer stalled for 3 cycles
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = $urandom; bp_b[i] = 8'($urandom);
        end
        sent = 0;
        for (int c = 0; c < 40 && sent < 4; c++) begin
            out_ready = (c >= 3);
            in_valid  = 1'b1;
            a = bp_a[sent]; b = bp_b[sent]; cfg = 2'b10;
            if (c == 2) begin
                #1;
                chk("bp_in_ready_low", 64'(bus3.in_ready), 64'd0);
            end
            cycle(acc);
            if (acc) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) cycle(acc);

        // Randomized traffic with enable gaps and consumer stalls
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cfg       = 2'($urandom_range(0, 3));
            a         = $urandom;
            b         = 8'($urandom);
            cycle(acc);
        end
        en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) cycle(acc);

        // Reset with two beats in flight and the consumer stalled
        out_ready = 1'b0; in_valid = 1'b1; cfg = 2'b10;
        a = $urandom; b = 8'($urandom);
        cycle(acc);
        a = $urandom; b = 8'($urandom);
        cycle(acc);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid3", 64'(bus3.out_valid), 64'd0);
        chk("arst_out_valid1", 64'(bus1.out_valid), 64'd0);
        chk("arst_c3",         64'(bus3.C),         64'd0);
        chk("arst_c1",         64'(bus1.C),         64'd0);
        chk("arst_cfg_err",    64'(bus3.cfg_err),   64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        repeat (6) cycle(acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
